// File: rtl/div_pkg.sv
// Shared definitions for the restoring shift-subtract divider.
//   - div_state_e  : controller state encoding (3-bit)
//   - ALU_ADD/SUB  : ALU operation codes, also used by the datapath registers
//   - ITER_DEFAULT : default number of quotient bits / iterations
//   - CNT_W_DEFAULT: default iteration counter width (2**CNT_W > ITER)
package div_pkg;

   localparam int unsigned ITER_DEFAULT  = 32;
   localparam int unsigned CNT_W_DEFAULT = 6;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StInit  = 3'd1,
      StShl0  = 3'd2,
      StSub   = 3'd3,
      StShift = 3'd4,
      StFinal = 3'd5,
      StDone  = 3'd6
   } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider controller.
// Ports:
//   clk   - system clock, rising edge
//   Reset - asynchronous active-high reset, clears the count
//   clear - synchronous clear (has priority over inc)
//   inc   - advance the count by one
//   last  - high while count == ITER-1
module div_iter_counter
   import div_pkg::*;
#(
   parameter int unsigned ITER  = ITER_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic Reset,
   input  logic clear,
   input  logic inc,
   output logic last
);

   localparam logic [CNT_W-1:0] LastVal = CNT_W'(ITER - 1);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign last = (count_q == LastVal);

endmodule

// File: rtl/div_controller.sv
// Control FSM for the 32-bit restoring shift-subtract divider. Sequences the
// Divisor register, the 64-bit Remainder register and the ALU; never touches
// operand data itself.
//
// Sequence: IDLE -Run-> INIT -> SHL0 -> (SUB -> SHIFT) x ITER -> FINAL -> DONE -> IDLE
//
// Ports:
//   clk          - system clock, rising edge
//   Reset        - asynchronous active-high reset
//   Run          - start request, sampled in IDLE only
//   ALU_carry    - 1 when Remainder_hi - Divisor does not borrow
//   Divisor_zero - divisor operand is zero (used only with DIV_ZERO_CHECK_EN)
//   W_ctrl       - Divisor register write enable
//   Rem_load     - load Remainder with {32'h0, dividend}
//   Rem_shl      - shift Remainder left by one, LSB <= Shl_bit
//   Shl_bit      - bit inserted on Rem_shl
//   Rem_wr_hi    - write ALU result into Remainder[63:32]
//   Rem_shr_hi   - shift Remainder[63:32] right by one
//   ALU_op       - ALU_ADD / ALU_SUB
//   Busy         - operation in progress (INIT through FINAL)
//   Ready        - one-cycle completion pulse
//   Div_zero     - divide-by-zero flag
//
// Optional feature macro: DIV_ZERO_CHECK_EN. When defined, a zero divisor seen
// in INIT skips straight to DONE and raises Div_zero until the next accepted
// Run or Reset. When undefined, Div_zero is tied low.
module div_controller
   import div_pkg::*;
#(
   parameter int unsigned ITER  = ITER_DEFAULT,
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic Reset,
   input  logic Run,
   input  logic ALU_carry,
   input  logic Divisor_zero,
   output logic W_ctrl,
   output logic Rem_load,
   output logic Rem_shl,
   output logic Shl_bit,
   output logic Rem_wr_hi,
   output logic Rem_shr_hi,
   output logic ALU_op,
   output logic Busy,
   output logic Ready,
   output logic Div_zero
);

   div_state_e state_q;

   logic q_bit_q;
   logic w_ctrl_q;
   logic rem_load_q;
   logic rem_shl_q;
   logic alu_sub_q;
   logic rem_shr_hi_q;
   logic busy_q;
   logic ready_q;
   logic cnt_last;

   div_iter_counter #(
      .ITER  (ITER),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (clk),
      .Reset (Reset),
      .clear (state_q == StDone),
      .inc   (state_q == StShift),
      .last  (cnt_last)
   );

`ifdef DIV_ZERO_CHECK_EN
   logic div_zero_q;
`else
   logic unused_divisor_zero;
   assign unused_divisor_zero = Divisor_zero;
`endif

   // Strobes are registered as the decode of the state being entered, so each
   // output is high exactly while the FSM sits in the corresponding state.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= StIdle;
         q_bit_q      <= 1'b0;
         w_ctrl_q     <= 1'b0;
         rem_load_q   <= 1'b0;
         rem_shl_q    <= 1'b0;
         alu_sub_q    <= 1'b0;
         rem_shr_hi_q <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
         div_zero_q   <= 1'b0;
`endif
      end else begin
         w_ctrl_q     <= 1'b0;
         rem_load_q   <= 1'b0;
         rem_shl_q    <= 1'b0;
         alu_sub_q    <= 1'b0;
         rem_shr_hi_q <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (Run) begin
                  state_q    <= StInit;
                  w_ctrl_q   <= 1'b1;
                  rem_load_q <= 1'b1;
                  busy_q     <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
                  div_zero_q <= 1'b0;
`endif
               end
            end
            StInit: begin
`ifdef DIV_ZERO_CHECK_EN
               if (Divisor_zero) begin
                  state_q    <= StDone;
                  ready_q    <= 1'b1;
                  div_zero_q <= 1'b1;
               end else
`endif
               begin
                  state_q   <= StShl0;
                  rem_shl_q <= 1'b1;
                  busy_q    <= 1'b1;
                  // SHL0 inserts a 0; clear any quotient bit left from a prior run.
                  q_bit_q   <= 1'b0;
               end
            end
            StShl0: begin
               state_q   <= StSub;
               alu_sub_q <= 1'b1;
               busy_q    <= 1'b1;
            end
            StSub: begin
               state_q   <= StShift;
               q_bit_q   <= ALU_carry;
               rem_shl_q <= 1'b1;
               busy_q    <= 1'b1;
            end
            StShift: begin
               busy_q <= 1'b1;
               if (cnt_last) begin
                  state_q      <= StFinal;
                  rem_shr_hi_q <= 1'b1;
               end else begin
                  state_q   <= StSub;
                  alu_sub_q <= 1'b1;
               end
            end
            StFinal: begin
               state_q <= StDone;
               ready_q <= 1'b1;
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign W_ctrl     = w_ctrl_q;
   assign Rem_load   = rem_load_q;
   assign Rem_shl    = rem_shl_q;
   // q_bit_q is 0 during SHL0 and holds the latched carry during SHIFT.
   assign Shl_bit    = rem_shl_q & q_bit_q;
   // Restoring step: only commit the difference when it did not borrow.
   assign Rem_wr_hi  = alu_sub_q & ALU_carry;
   assign Rem_shr_hi = rem_shr_hi_q;
   assign ALU_op     = alu_sub_q ? ALU_SUB : ALU_ADD;
   assign Busy       = busy_q;
   assign Ready      = ready_q;
`ifdef DIV_ZERO_CHECK_EN
   assign Div_zero   = div_zero_q;
`else
   assign Div_zero   = 1'b0;
`endif

endmodule

// File: tb/tb_div_controller.sv
`timescale 1ns/1ps
module tb_div_controller;

   logic clk = 1'b0;
   logic Reset, Run, Divisor_zero;
   logic W_ctrl, Rem_load, Rem_shl, Shl_bit, Rem_wr_hi, Rem_shr_hi, ALU_op;
   logic Busy, Ready, Div_zero;

   // Carry source: 0 = constant carry_drv, 1 = alternating, 2 = datapath model.
   logic [1:0]  mode = 2'd0;
   logic        carry_drv = 1'b1;
   logic [31:0] dividend = '0, divisor = '0, dp_div = '0;
   logic [63:0] dp_rem = '0;
   logic        alu_carry;

   assign alu_carry = (mode == 2'd2) ? (dp_rem[63:32] >= dp_div) : carry_drv;

   always #5 clk = ~clk;

   div_controller dut (
      .clk          (clk),
      .Reset        (Reset),
      .Run          (Run),
      .ALU_carry    (alu_carry),
      .Divisor_zero (Divisor_zero),
      .W_ctrl       (W_ctrl),
      .Rem_load     (Rem_load),
      .Rem_shl      (Rem_shl),
      .Shl_bit      (Shl_bit),
      .Rem_wr_hi    (Rem_wr_hi),
      .Rem_shr_hi   (Rem_shr_hi),
      .ALU_op       (ALU_op),
      .Busy         (Busy),
      .Ready        (Ready),
      .Div_zero     (Div_zero)
   );

   typedef struct {
      int unsigned rdy_cyc;
      int unsigned shl;
      int unsigned wrhi;
      logic [31:0] sig;
      int unsigned shr;
      int unsigned sub;
      int unsigned busy;
      logic        dz;
      logic        chk_dp;
      logic [31:0] q;
      logic [31:0] r;
   } exp_t;

   exp_t exp_q[$];

   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int unsigned rdy, input int unsigned shl,
                               input int unsigned wrhi, input logic [31:0] sig,
                               input int unsigned shr, input int unsigned sub,
                               input int unsigned busy, input logic dz, input logic chk_dp,
                               input logic [31:0] q, input logic [31:0] r);
      exp_t e;
      e.rdy_cyc = rdy; e.shl = shl; e.wrhi = wrhi; e.sig = sig; e.shr = shr;
      e.sub = sub; e.busy = busy; e.dz = dz; e.chk_dp = chk_dp; e.q = q; e.r = r;
      return e;
   endfunction

   function automatic logic [9:0] outs();
      return {W_ctrl, Rem_load, Rem_shl, Shl_bit, Rem_wr_hi, Rem_shr_hi, ALU_op,
              Busy, Ready, Div_zero};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int unsigned n_shl, n_wrhi, n_shr, n_sub, n_busy, n_w;
   logic [31:0] sig;
   logic ld_bad, shl0_bad;
   logic idle_bad = 1'b0;
   logic s_load, s_w, s_shl, s_shl_bit, s_wr_hi, s_shr, s_op;

   always @(negedge clk) begin
      exp_t e;
      if (Reset) begin
         n_shl = 0; n_wrhi = 0; n_shr = 0; n_sub = 0; n_busy = 0; n_w = 0; sig = '0;
         ld_bad = 1'b0; shl0_bad = 1'b0;
         s_load = 1'b0; s_w = 1'b0; s_shl = 1'b0; s_shl_bit = 1'b0;
         s_wr_hi = 1'b0; s_shr = 1'b0; s_op = 1'b0;
      end else begin
         if (W_ctrl) begin
            n_shl = 0; n_wrhi = 0; n_shr = 0; n_sub = 0; n_busy = 0; n_w = 0; sig = '0;
            ld_bad = 1'b0; shl0_bad = 1'b0;
            n_w++;
         end
         if (W_ctrl != Rem_load) ld_bad = 1'b1;
         if ((W_ctrl | Rem_load | Rem_shl | Rem_wr_hi | Rem_shr_hi | ALU_op) && !Busy)
            idle_bad = 1'b1;
         if (Busy) n_busy++;
         if (Rem_shl) begin
            if (n_shl == 0) begin
               if (Shl_bit) shl0_bad = 1'b1;
            end else begin
               sig = {sig[30:0], Shl_bit};
            end
            n_shl++;
         end
         if (Rem_wr_hi) n_wrhi++;
         if (ALU_op) n_sub++;
         if (Rem_shr_hi) n_shr++;
         s_load = Rem_load; s_w = W_ctrl; s_shl = Rem_shl; s_shl_bit = Shl_bit;
         s_wr_hi = Rem_wr_hi; s_shr = Rem_shr_hi; s_op = ALU_op;
         // Iteration i's SUB sees n_shl == i+1; carry on even iterations.
         if (mode == 2'd1) carry_drv = ((n_shl % 2) == 1);
         if (Ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_ready", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("ready_cycle", 64'(cyc), 64'(e.rdy_cyc));
               chk("busy_at_ready", 64'(Busy), 64'd0);
               chk("shl_count", 64'(n_shl), 64'(e.shl));
               chk("wr_hi_count", 64'(n_wrhi), 64'(e.wrhi));
               chk("shl_bit_pattern", 64'(sig), 64'(e.sig));
               chk("shr_hi_count", 64'(n_shr), 64'(e.shr));
               chk("sub_count", 64'(n_sub), 64'(e.sub));
               chk("busy_cycles", 64'(n_busy), 64'(e.busy));
               chk("w_ctrl_count", 64'(n_w), 64'd1);
               chk("load_with_w_ctrl", 64'(ld_bad), 64'd0);
               chk("shl0_bit", 64'(shl0_bad), 64'd0);
               chk("div_zero", 64'(Div_zero), 64'(e.dz));
               if (e.chk_dp) begin
                  chk("quotient", 64'(dp_rem[31:0]), 64'(e.q));
                  chk("remainder", 64'(dp_rem[63:32]), 64'(e.r));
               end
            end
         end
      end
   end

   // Datapath model driven by the strobes captured on the previous negedge.
   always @(posedge clk) begin
      logic [31:0] alu_res;
      alu_res = s_op ? (dp_rem[63:32] - dp_div) : (dp_rem[63:32] + dp_div);
      if (s_load)       dp_rem <= {32'h0, dividend};
      else if (s_shl)   dp_rem <= {dp_rem[62:0], s_shl_bit};
      else if (s_wr_hi) dp_rem[63:32] <= alu_res;
      else if (s_shr)   dp_rem[63:32] <= dp_rem[63:32] >> 1;
      if (s_w) dp_div <= divisor;
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [1:0] m, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic dzi, input exp_t e, output int unsigned base);
      @(negedge clk);
      mode = m; carry_drv = 1'b1; dividend = dvd; divisor = dvs; Divisor_zero = dzi;
      Run = 1'b1;
      @(posedge clk);
      #1;
      base = cyc;
      e.rdy_cyc = base + e.rdy_cyc;
      exp_q.push_back(e);
      @(negedge clk);
      Run = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         chk("ready_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t nom, e;
      int unsigned base;
      nom = mk(67, 33, 32, 32'hFFFF_FFFF, 1, 32, 67, 1'b0, 1'b0, '0, '0);

      // Reset held with Run high: everything low, no start afterwards.
      Reset = 1'b1; Run = 1'b1; Divisor_zero = 1'b0;
      #1 chk("reset_outs_early", 64'(outs()), 64'd0);
      #7 chk("reset_outs_late", 64'(outs()), 64'd0);
      Run = 1'b0;
      #2 Reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", 64'({Busy, W_ctrl, Ready}), 64'd0);

      // Nominal, constant carry.
      issue(2'd0, 32'd0, 32'd0, 1'b0, nom, base);
      drain();

      // Alternating carry 1,0,1,0...
      e = mk(67, 33, 16, 32'hAAAA_AAAA, 1, 32, 67, 1'b0, 1'b0, '0, '0);
      issue(2'd1, 32'd0, 32'd0, 1'b0, e, base);
      drain();

      // Zero divisor.
`ifdef DIV_ZERO_CHECK_EN
      e = mk(1, 0, 0, 32'h0, 0, 0, 1, 1'b1, 1'b0, '0, '0);
`else
      e = mk(67, 33, 32, 32'hFFFF_FFFF, 1, 32, 67, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd100);
`endif
      issue(2'd2, 32'd100, 32'd0, 1'b1, e, base);
      drain();

      // 100 / 7 through the datapath model; also clears any Div_zero.
      e = mk(67, 33, 3, 32'h0000_000E, 1, 32, 67, 1'b0, 1'b1, 32'd14, 32'd2);
      issue(2'd2, 32'd100, 32'd7, 1'b0, e, base);
      drain();

      // Run pulses while busy are ignored.
      issue(2'd0, 32'd0, 32'd0, 1'b0, nom, base);
      while (cyc != base + 4) @(negedge clk);
      Run = 1'b1;
      @(negedge clk) Run = 1'b0;
      while (cyc != base + 39) @(negedge clk);
      Run = 1'b1;
      @(negedge clk) Run = 1'b0;
      drain();

      // Run held high: back-to-back ops with one IDLE cycle in between.
      @(negedge clk);
      mode = 2'd0; carry_drv = 1'b1; Run = 1'b1;
      @(posedge clk);
      #1;
      base = cyc;
      e = nom; e.rdy_cyc = base + 67;  exp_q.push_back(e);
      e = nom; e.rdy_cyc = base + 136; exp_q.push_back(e);
      while (cyc != base + 70) @(negedge clk);
      Run = 1'b0;
      drain();

      // Asynchronous reset mid-operation, then a fresh run.
      issue(2'd0, 32'd0, 32'd0, 1'b0, nom, base);
      while (cyc != base + 19) @(negedge clk);
      chk("busy_before_mid_reset", 64'(Busy), 64'd1);
      #2 Reset = 1'b1;
      #1 chk("mid_reset_outs", 64'(outs()), 64'd0);
      void'(exp_q.pop_back());
      @(posedge clk);
      @(negedge clk) Reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_after_mid_reset", 64'({Busy, Ready}), 64'd0);
      issue(2'd0, 32'd0, 32'd0, 1'b0, nom, base);
      drain();

      chk("strobe_outside_busy", 64'(idle_bad), 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
